// File: rtl/stall_ctrl_pkg.sv
// Shared types and encodings for the ID-stage stall controller.
// Tuse/Tnew encodings follow the decode stage's classification of each instruction.
package stall_ctrl_pkg;

    localparam int MD_CNT_W = 4;

    typedef logic [4:0]          reg_idx_t;
    typedef logic [1:0]          tuse_t;
    typedef logic [1:0]          tnew_t;
    typedef logic [MD_CNT_W-1:0] md_cnt_t;

    localparam tuse_t TUSE_BRANCH = 2'd0;
    localparam tuse_t TUSE_ALU    = 2'd1;
    localparam tuse_t TUSE_STORE  = 2'd2;
    localparam tuse_t TUSE_NONE   = 2'd3;

    localparam tnew_t TNEW_NONE = 2'd0;
    localparam tnew_t TNEW_ALU  = 2'd1;
    localparam tnew_t TNEW_LOAD = 2'd2;

    // One shadowed pipeline stage: destination register and cycles until its result exists.
    typedef struct packed {
        reg_idx_t rd;
        tnew_t    tnew;
    } sb_entry_t;

    function automatic tnew_t age_tnew(input tnew_t tnew);
        return (tnew == TNEW_NONE) ? TNEW_NONE : tnew_t'(tnew - 2'd1);
    endfunction

    // A source stalls when its producer is still in flight and cannot forward in time.
    function automatic logic src_hazard(input reg_idx_t src, input tuse_t tuse,
                                        input sb_entry_t ent);
        return (src != '0) && (src == ent.rd) && (tuse != TUSE_NONE) && (ent.tnew > tuse);
    endfunction

endpackage

// File: rtl/stall_ctrl_if.sv
// Decode-side bundle: ID instruction attributes in, stall and hold enables back out.
interface stall_ctrl_if;
    import stall_ctrl_pkg::*;

    reg_idx_t id_rs;
    reg_idx_t id_rt;
    tuse_t    id_tuse_rs;
    tuse_t    id_tuse_rt;
    reg_idx_t id_wr_reg;
    tnew_t    id_tnew;
    logic     id_md_start;
    logic     id_md_is_div;
    logic     id_md_use;
    logic     stall;
    logic     pc_en;
    logic     if_id_en;
    logic     md_busy;

    modport master (
        output id_rs, id_rt, id_tuse_rs, id_tuse_rt, id_wr_reg, id_tnew,
               id_md_start, id_md_is_div, id_md_use,
        input  stall, pc_en, if_id_en, md_busy
    );

    modport slave (
        input  id_rs, id_rt, id_tuse_rs, id_tuse_rt, id_wr_reg, id_tnew,
               id_md_start, id_md_is_div, id_md_use,
        output stall, pc_en, if_id_en, md_busy
    );

endinterface

// File: rtl/stall_ctrl_md_busy_counter.sv
// Down-counter modelling the multi-cycle mult/div unit; loads when the op sits in EX.
module stall_ctrl_md_busy_counter
    import stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    load,
    input  logic    is_div,
    output md_cnt_t md_cnt,
    output logic    md_busy
);

    localparam md_cnt_t MULT_LOAD = md_cnt_t'(MULT_CYCLES);
    localparam md_cnt_t DIV_LOAD  = md_cnt_t'(DIV_CYCLES);
    localparam md_cnt_t CNT_ONE   = md_cnt_t'(1);

    md_cnt_t md_cnt_d;
    md_cnt_t md_cnt_q;

    always_comb begin
        md_cnt_d = md_cnt_q;
        if (reset) begin
            md_cnt_d = '0;
        end else if (load) begin
            md_cnt_d = is_div ? DIV_LOAD : MULT_LOAD;
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        md_cnt_q <= md_cnt_d;
    end

    assign md_cnt  = md_cnt_q;
    assign md_busy = (md_cnt_q != '0);

endmodule

// File: rtl/stall_ctrl.sv
// ID-stage stall generation: EX/MEM scoreboard for RAW hazards plus mult/div busy interlock.
// Stall is purely combinational from the ID inputs and the registered scoreboard.
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic         clk,
    input  logic         reset,
    stall_ctrl_if.slave  id_if
);

    sb_entry_t ex_d,     ex_q;
    logic      ex_md_d,  ex_md_q;
    logic      ex_div_d, ex_div_q;
    sb_entry_t mem_d,    mem_q;

    md_cnt_t   md_cnt;
    logic      md_busy;

    logic      hazard_rs;
    logic      hazard_rt;
    logic      md_term;
    logic      stall_raw;

    stall_ctrl_md_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_cnt (
        .clk     (clk),
        .reset   (reset),
        .load    (ex_md_q),
        .is_div  (ex_div_q),
        .md_cnt  (md_cnt),
        .md_busy (md_busy)
    );

    // EX and MEM matches are simply ORed; checking EX first would give the same answer.
    always_comb begin
        hazard_rs = src_hazard(id_if.id_rs, id_if.id_tuse_rs, ex_q)
                  | src_hazard(id_if.id_rs, id_if.id_tuse_rs, mem_q);
        hazard_rt = src_hazard(id_if.id_rt, id_if.id_tuse_rt, ex_q)
                  | src_hazard(id_if.id_rt, id_if.id_tuse_rt, mem_q);
        // ex_md closes the one-cycle gap before the counter has been loaded.
        md_term   = id_if.id_md_use && ((md_cnt != '0) || ex_md_q);
        stall_raw = hazard_rs | hazard_rt | md_term;
    end

    always_comb begin
        ex_d     = ex_q;
        ex_md_d  = ex_md_q;
        ex_div_d = ex_div_q;
        mem_d    = mem_q;
        if (reset) begin
            ex_d     = '0;
            ex_md_d  = 1'b0;
            ex_div_d = 1'b0;
            mem_d    = '0;
        end else begin
            // A stalled instruction leaves a bubble in EX, mirroring the ID/EX register.
            if (stall_raw) begin
                ex_d     = '0;
                ex_md_d  = 1'b0;
                ex_div_d = 1'b0;
            end else begin
                ex_d.rd   = id_if.id_wr_reg;
                ex_d.tnew = id_if.id_tnew;
                ex_md_d   = id_if.id_md_start;
                ex_div_d  = id_if.id_md_start & id_if.id_md_is_div;
            end
            mem_d.rd   = ex_q.rd;
            mem_d.tnew = age_tnew(ex_q.tnew);
        end
    end

    always_ff @(posedge clk) begin
        ex_q     <= ex_d;
        ex_md_q  <= ex_md_d;
        ex_div_q <= ex_div_d;
        mem_q    <= mem_d;
    end

    assign id_if.stall    = !reset && stall_raw;
    assign id_if.pc_en    = !id_if.stall;
    assign id_if.if_id_en = !id_if.stall;
    assign id_if.md_busy  = md_busy;

endmodule
